// File: rtl/dac_i2s_tx_ctrl.sv
// Master-mode serial-port transmitter for the WM8731 DAC.
// Divides clk into b_clk and dac_lr_clk. Accepts 32-bit stereo words {L,R}
// through a one-deep holding register. Shifts each word out MSB-first,
// left-justified: L while dac_lr_clk is high, R while it is low.
module dac_i2s_tx_ctrl #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        b_clk,
    output logic        dac_lr_clk,
    output logic        dacdat,
    output logic        frame_start,
    output logic        underrun
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic [4:0]       bit_cnt_r;
    logic [31:0]      shift_r;
    logic [31:0]      hold_reg_r;
    logic             hold_full_r;
    logic             b_clk_r;
    logic             dac_lr_clk_r;
    logic             dacdat_r;
    logic             frame_start_r;
    logic             underrun_r;

    logic             div_wrap_s;
    logic             rise_s;
    logic [4:0]       bit_next_s;
    logic             frame_s;
    logic             accept_s;

    // Decode the divider wrap, the b_clk rising event and the frame boundary.
    always_comb begin
        div_wrap_s = (div_cnt_r == DIV_LAST);
        bit_next_s = bit_cnt_r + 5'd1;
        rise_s     = 1'b0;
        frame_s    = 1'b0;
        if (enable && div_wrap_s && !b_clk_r) begin
            rise_s  = 1'b1;
            frame_s = (bit_next_s == 5'd0);
        end else begin
            rise_s  = 1'b0;
            frame_s = 1'b0;
        end
        // A full holding register is never written, so a load and an accept
        // can never fall in the same cycle.
        accept_s = sample_valid & ~hold_full_r;
    end

    assign sample_ready = ~hold_full_r;
    assign b_clk        = b_clk_r;
    assign dac_lr_clk   = dac_lr_clk_r;
    assign dacdat       = dacdat_r;
    assign frame_start  = frame_start_r;
    assign underrun     = underrun_r;

    // Holding register: filled by the handshake and emptied at each frame start.
    // It is kept while the port is disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg_r  <= 32'd0;
            hold_full_r <= 1'b0;
        end else if (frame_s && hold_full_r) begin
            hold_full_r <= 1'b0;
        end else if (accept_s) begin
            hold_reg_r  <= sample_in;
            hold_full_r <= 1'b1;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    // Clock divider, bit counter and output shifter.
    // Disabling the port drops the partial frame and returns to the frame-start position.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_r     <= '0;
            bit_cnt_r     <= 5'd31;
            shift_r       <= 32'd0;
            b_clk_r       <= 1'b0;
            dac_lr_clk_r  <= 1'b0;
            dacdat_r      <= 1'b0;
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else begin
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
            if (!enable) begin
                div_cnt_r    <= '0;
                bit_cnt_r    <= 5'd31;
                shift_r      <= 32'd0;
                b_clk_r      <= 1'b0;
                dac_lr_clk_r <= 1'b0;
                dacdat_r     <= 1'b0;
            end else begin
                if (div_wrap_s) begin
                    div_cnt_r <= '0;
                    b_clk_r   <= ~b_clk_r;
                end else begin
                    div_cnt_r <= div_cnt_r + DIV_W'(1);
                end
                if (rise_s) begin
                    bit_cnt_r    <= bit_next_s;
                    dac_lr_clk_r <= (bit_next_s < 5'd16);
                    if (frame_s) begin
                        frame_start_r <= 1'b1;
                        if (hold_full_r) begin
                            shift_r  <= hold_reg_r;
                            dacdat_r <= hold_reg_r[31];
                        end else begin
                            shift_r    <= 32'd0;
                            dacdat_r   <= 1'b0;
                            underrun_r <= 1'b1;
                        end
                    end else begin
                        dacdat_r <= shift_r[30];
                        shift_r  <= {shift_r[30:0], 1'b0};
                    end
                end else begin
                    bit_cnt_r <= bit_cnt_r;
                end
            end
        end
    end

endmodule
